bug_0_seq_eval: RTL and testbench
=================================

# bug_0_seq_eval

Sequential evaluator for the bug_0 regression network (pi0..pi5 -> po0..po4). The block does not build the network as parallel gates. It time-multiplexes one shared 2-input AND/OR unit over a fixed node schedule, one node per clock, with a start/done handshake. The sinkless node n4 is dropped from the schedule by default. This block is the sequential reference against which the combinational bug_0 netlist is equivalence-checked in the regression flow.

## Interface
- SKIP_DEAD, default 1: 1 = omit the sinkless node n4 from the schedule (8 steps); 0 = evaluate n4 into a scratch register that is never read (9 steps).
- clk  input  1  single clock; all state updates on the rising edge.
- rst_n  input  1  reset, asynchronous and active-low.
- start  input  1  request one evaluation; sampled only in IDLE.
- pi  input  6  primary inputs; pi[0]=pi0 … pi[5]=pi5; captured on the accepting edge.
- busy  output  1  evaluation in progress.
- done  output  1  one-cycle pulse; po is valid and updated in this cycle.
- po  output  5  results; po[0]=po0 … po[4]=po4; held between evaluations.

## Operation
- Operand file: 6 captured pi bits, n1..n3, po0..po4 working copies, and an n4 scratch bit (unused when SKIP_DEAD=1).
- Schedule ROM, executed in this order, one entry per EVAL cycle:
  - n1 = pi0 & pi1
  - n2 = pi2 | pi3
  - n3 = pi4 | pi5
  - (n4 = n1 | n2, only if SKIP_DEAD=0)
  - po0 = n1 & n2
  - po1 = n2 | n3
  - po2 = po1 & n1
  - po3 = n3 & pi2
  - po4 = n1 & pi2
- Each ROM entry holds operand A select, operand B select, op (AND/OR) and destination. Exactly one ALU operation per cycle. An operand is always written at least one cycle before any step reads it, so no bypass is needed.
- FSM states: IDLE, EVAL, DONE.
  - IDLE: if start=1, capture pi into the operand file, clear step to 0, go to EVAL. Otherwise stay.
  - EVAL: execute ROM[step] and write the result. If step is LAST (7, or 8 when SKIP_DEAD=0), go to DONE. Otherwise increment step.
  - DONE: copy working po0..po4 to the po output register, pulse done, go to IDLE.
- start while busy=1 is ignored; it is not queued.
- pi changes after capture have no effect on the current evaluation.
- Step counter is 4 bits and never wraps; the LAST compare ends EVAL.
- Reset (any state, including mid-EVAL) forces:
  - state=IDLE, step=0, busy=0, done=0, po=5'b00000
  - operand file cleared
  - any evaluation in progress is discarded, and no done is issued for it.

## Timing
- Start accepted at edge k. busy=1 from after edge k.
- EVAL steps are written at edges k+1 … k+8 (k+1 … k+9 when SKIP_DEAD=0).
- DONE→IDLE edge is k+9 (k+10):
  - po updates at this edge
  - done=1 for exactly one cycle
  - busy=0 at the same time.
- Latency from start to done is 9 cycles (10 when SKIP_DEAD=0).
- Throughput: start may be held high or reasserted in the done cycle (state is IDLE), giving back-to-back evaluations every 10 cycles (11 when SKIP_DEAD=0).
- Between done pulses, po holds its last value. po never shows partial results.
- All outputs are registered. No combinational path from start or pi to any output.

## Test plan
- Reset then idle: rst_n low mid-cycle -> busy=0, done=0, po=5'b00000 immediately (async). With start=0 for 20 cycles -> no done.
- pi=6'b111111, single start pulse -> done exactly 9 cycles later, po=5'b11111. busy is high for cycles 1-9 after accept.
- pi=6'b000111 -> po=5'b10111. Then pi=6'b110000 back-to-back (start held high) -> second done 10 cycles after the first, po=5'b00010.
- Start pulsed again at cycle 4 of an evaluation, and pi changed to 6'b000000 mid-EVAL -> ignored. Result still matches the captured pi. Only one done pulse.
- Reset asserted at EVAL step 5, then released -> no done pulse, po=5'b00000. A fresh start with pi=6'b000011 -> po=5'b00000 after 9 cycles.
- SKIP_DEAD=0 build, pi=6'b111111 -> done after 10 cycles, po=5'b11111. Exhaustive sweep of all 64 pi values -> po matches the combinational bug_0 equations in both builds.

Source files
------------

// File: rtl/bug_0_seq_eval.sv
// bug_0_seq_eval
// Sequential evaluator for the bug_0 regression network (pi0..pi5 -> po0..po4).
// A single shared 2-input AND/OR unit walks a fixed node schedule, one node per
// clock, between a start request and a one-cycle done pulse.
//
// Parameters:
//   SKIP_DEAD  1: drop the sinkless node n4 from the schedule (8 steps)
//              0: evaluate n4 into a scratch bit that is never read (9 steps)
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   start  evaluation request, sampled only while idle
//   pi     primary inputs, captured on the accepting edge
//   busy   evaluation in progress
//   done   one-cycle pulse; po updated in the same cycle
//   po     registered results, held between evaluations
module bug_0_seq_eval #(
    parameter bit SKIP_DEAD = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [5:0] pi,
    output logic       busy,
    output logic       done,
    output logic [4:0] po
);

    // Operand file layout: captured pi, internal nodes, n4 scratch, po working copies.
    localparam logic [3:0] SelPi0 = 4'd0;
    localparam logic [3:0] SelPi1 = 4'd1;
    localparam logic [3:0] SelPi2 = 4'd2;
    localparam logic [3:0] SelPi3 = 4'd3;
    localparam logic [3:0] SelPi4 = 4'd4;
    localparam logic [3:0] SelPi5 = 4'd5;
    localparam logic [3:0] SelN1  = 4'd6;
    localparam logic [3:0] SelN2  = 4'd7;
    localparam logic [3:0] SelN3  = 4'd8;
    localparam logic [3:0] SelN4  = 4'd9;
    localparam logic [3:0] SelPo0 = 4'd10;
    localparam logic [3:0] SelPo1 = 4'd11;
    localparam logic [3:0] SelPo2 = 4'd12;
    localparam logic [3:0] SelPo3 = 4'd13;
    localparam logic [3:0] SelPo4 = 4'd14;

    localparam logic OpAnd = 1'b0;
    localparam logic OpOr  = 1'b1;

    localparam logic [3:0] LastStep = SKIP_DEAD ? 4'd7 : 4'd8;

    typedef enum logic [1:0] {
        StIdle,
        StEval,
        StDone
    } state_e;

    typedef struct packed {
        logic [3:0] a_sel;
        logic [3:0] b_sel;
        logic       op;
        logic [3:0] dst;
    } rom_entry_t;

    // Full 9-entry schedule; entry 3 (n4) is skipped by index remapping.
    function automatic rom_entry_t rom_lookup(input logic [3:0] idx);
        rom_entry_t e;
        case (idx)
            4'd0:    e = '{SelPi0, SelPi1, OpAnd, SelN1};
            4'd1:    e = '{SelPi2, SelPi3, OpOr,  SelN2};
            4'd2:    e = '{SelPi4, SelPi5, OpOr,  SelN3};
            4'd3:    e = '{SelN1,  SelN2,  OpOr,  SelN4};
            4'd4:    e = '{SelN1,  SelN2,  OpAnd, SelPo0};
            4'd5:    e = '{SelN2,  SelN3,  OpOr,  SelPo1};
            4'd6:    e = '{SelPo1, SelN1,  OpAnd, SelPo2};
            4'd7:    e = '{SelN3,  SelPi2, OpAnd, SelPo3};
            4'd8:    e = '{SelN1,  SelPi2, OpAnd, SelPo4};
            // Unreachable; aim any stray write at the unused scratch bit.
            default: e = '{SelPi0, SelPi0, OpAnd, SelN4};
        endcase
        return e;
    endfunction

    state_e      state_q, state_d;
    logic [3:0]  step_q, step_d;
    logic [14:0] opf_q, opf_d;
    logic [4:0]  po_q, po_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;

    logic [3:0]  rom_idx;
    rom_entry_t  entry;
    logic        opa, opb, alu_res;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            step_q  <= 4'd0;
            opf_q   <= '0;
            po_q    <= 5'b00000;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            opf_q   <= opf_d;
            po_q    <= po_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        opf_d   = opf_q;
        po_d    = po_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        // With n4 dropped, steps 3.. map onto ROM entries 4..
        rom_idx = (SKIP_DEAD && (step_q >= 4'd3)) ? (step_q + 4'd1) : step_q;
        entry   = rom_lookup(rom_idx);
        opa     = opf_q[entry.a_sel];
        opb     = opf_q[entry.b_sel];
        alu_res = (entry.op == OpOr) ? (opa | opb) : (opa & opb);

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    opf_d      = '0;
                    opf_d[5:0] = pi;
                    step_d     = 4'd0;
                    busy_d     = 1'b1;
                    state_d    = StEval;
                end
            end
            StEval: begin
                opf_d[entry.dst] = alu_res;
                if (step_q == LastStep) begin
                    state_d = StDone;
                end else begin
                    step_d = step_q + 4'd1;
                end
            end
            StDone: begin
                // Publish all results at once so po never shows partial values.
                po_d    = opf_q[SelPo4:SelPo0];
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    assign busy = busy_q;
    assign done = done_q;
    assign po   = po_q;

endmodule

// File: tb/tb_bug_0_seq_eval.sv
// Self-checking bench for bug_0_seq_eval: directed scenarios plus randomized and
// exhaustive pi sweeps on both the default (8-step) and SKIP_DEAD=0 (9-step) builds.
module tb_bug_0_seq_eval;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [5:0] pi;
    logic       busy8, done8;
    logic [4:0] po8;
    logic       busy9, done9;
    logic [4:0] po9;

    logic       sel;        // 0: default build, 1: SKIP_DEAD=0 build
    logic       cur_busy, cur_done;
    logic [4:0] cur_po;

    int n_cmp  = 0;
    int n_fail = 0;

    bug_0_seq_eval dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .pi    (pi),
        .busy  (busy8),
        .done  (done8),
        .po    (po8)
    );

    bug_0_seq_eval #(.SKIP_DEAD(1'b0)) dut9 (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .pi    (pi),
        .busy  (busy9),
        .done  (done9),
        .po    (po9)
    );

    assign cur_busy = sel ? busy9 : busy8;
    assign cur_done = sel ? done9 : done8;
    assign cur_po   = sel ? po9 : po8;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: the bug_0 network as plain boolean equations.
    function automatic logic [4:0] ref_po(input logic [5:0] p);
        logic n1, n2, n3;
        logic [4:0] r;
        n1 = p[0] & p[1];
        n2 = p[2] | p[3];
        n3 = p[4] | p[5];
        r[0] = n1 & n2;
        r[1] = n2 | n3;
        r[2] = r[1] & n1;
        r[3] = n3 & p[2];
        r[4] = n1 & p[2];
        return r;
    endfunction

    function automatic int exp_lat(input logic s);
        return s ? 10 : 9;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Counts edges until done; busy must stay high until then. lat=-1 on timeout.
    task automatic wait_done(output int lat, output int busy_bad);
        lat = -1;
        busy_bad = 0;
        for (int i = 1; i <= 40; i++) begin
            tick();
            if (cur_done) begin
                lat = i;
                break;
            end
            if (!cur_busy) busy_bad++;
        end
    endtask

    // One full evaluation with a single-cycle start pulse.
    task automatic run_eval(input string tag, input logic [5:0] v);
        int lat, bb;
        pi = v;
        start = 1'b1;
        tick();
        start = 1'b0;
        pi = ~v;  // later pi changes must not matter
        wait_done(lat, bb);
        check({tag, " latency"}, lat, exp_lat(sel));
        check({tag, " busy gap"}, bb, 0);
        check({tag, " busy in done"}, {31'd0, cur_busy}, 0);
        check({tag, " po"}, {27'd0, cur_po}, {27'd0, ref_po(v)});
        tick();
        check({tag, " done width"}, {31'd0, cur_done}, 0);
    endtask

    initial begin
        int lat, bb, cnt;
        logic [5:0] r;

        sel = 1'b0;
        rst_n = 1'b1;
        start = 1'b0;
        pi = 6'd0;

        // Asynchronous reset asserted mid-cycle.
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check("rst busy", {31'd0, busy8}, 0);
        check("rst done", {31'd0, done8}, 0);
        check("rst po", {27'd0, po8}, 0);
        check("rst po9", {27'd0, po9}, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Idle with start low: no done.
        cnt = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (done8 || done9 || busy8) cnt++;
        end
        check("idle activity", cnt, 0);

        run_eval("all ones", 6'b111111);

        // Back-to-back with start held high.
        pi = 6'b000111;
        start = 1'b1;
        tick();
        pi = 6'b110000;
        wait_done(lat, bb);
        check("b2b first latency", lat, 9);
        check("b2b first po", {27'd0, po8}, 5'b10111);
        tick();
        start = 1'b0;
        check("b2b accept busy", {31'd0, busy8}, 1);
        wait_done(lat, bb);
        check("b2b spacing", lat + 1, 10);
        check("b2b second po", {27'd0, po8}, 5'b00010);
        tick();

        // Start re-pulsed at cycle 4 and pi cleared mid-evaluation.
        r = 6'($urandom_range(1, 63));
        pi = r;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (3) tick();
        start = 1'b1;
        pi = 6'b000000;
        tick();
        start = 1'b0;
        wait_done(lat, bb);
        check("ignored start latency", lat + 4, 9);
        check("ignored start po", {27'd0, po8}, {27'd0, ref_po(r)});
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done8) cnt++;
        end
        check("ignored start extra done", cnt, 0);
        check("po held", {27'd0, po8}, {27'd0, ref_po(r)});

        // Reset during EVAL step 5 discards the evaluation.
        pi = 6'b111111;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (5) tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid rst po", {27'd0, po8}, 0);
        check("mid rst busy", {31'd0, busy8}, 0);
        #2 rst_n = 1'b1;
        cnt = 0;
        for (int i = 0; i < 15; i++) begin
            tick();
            if (done8 || busy8) cnt++;
        end
        check("mid rst no done", cnt, 0);
        check("mid rst po after", {27'd0, po8}, 0);
        run_eval("after rst", 6'b000011);

        // Randomized vectors, default build.
        for (int i = 0; i < 20; i++) begin
            run_eval("rand8", 6'($urandom));
        end

        // Exhaustive sweep in both builds.
        for (int s = 0; s < 2; s++) begin
            repeat (15) tick();
            sel = s[0];
            if (s == 1) run_eval("ones9", 6'b111111);
            for (int v = 0; v < 64; v++) begin
                run_eval(s == 0 ? "sweep8" : "sweep9", 6'(v));
            end
            for (int i = 0; i < 10; i++) begin
                run_eval(s == 0 ? "rsweep8" : "rsweep9", 6'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
